dec_round_key_sequencer: RTL
============================

Name: dec_round_key_sequencer

Overview:
Sequential key-supply stage for the BORON decryption datapath (80-bit key, 64-bit block, 25 rounds).
- Accepts the master key K0.
- Runs the forward key schedule for ROUNDS cycles to reach the last round key K25.
- Then streams round keys in reverse order (K25 down to K0) to the decryption round logic over a valid/ready handshake.
- Each backward step uses the existing combinational dec_key_scheduler step.

Parameters:
- ROUNDS, 25: number of cipher rounds; ROUNDS+1 round keys are emitted; must be ≤ 31.
- KEY_W, 80: key register width.
- RK_W, 64: round-key width; the round key is key[RK_W-1:0].
- ROT, 13: key-schedule rotation amount.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- key_load  in  1  request to load i_key; accepted only when busy=0.
- i_key  in  80  master key K0.
- busy  out  1  high from the cycle after load acceptance until done.
- rk_valid  out  1  o_round_key/o_round_idx hold a valid round key.
- rk_ready  in  1  consumer accepts the round key on this edge when rk_valid=1.
- o_round_key  out  64  current round key, key_reg[63:0].
- o_round_idx  out  5  index r of the key presented (ROUNDS down to 0).
- done  out  1  one-cycle pulse after K0 is accepted.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, key_reg=0, ctr=0.
  - busy=0, rk_valid=0, done=0, o_round_key=0, o_round_idx=0.
- Forward step F(K, r) produces K_r from K_{r-1}:
  - rotate left by ROT;
  - S-box on bits [3:0];
  - bits [63:59] ^= (r-1)[4:0].
- Backward step uses dec_key_scheduler with round_counter=r. It maps K_r to K_{r-1} exactly.
- States:
  - IDLE:
    - key_load=1 on an edge: key_reg<=i_key, ctr<=1, state<=EXPAND.
    - key_load is ignored in every other state.
  - EXPAND:
    - Each edge: key_reg<=F(key_reg, ctr), ctr<=ctr+1.
    - On the edge where ctr==ROUNDS: state<=EMIT, ctr holds ROUNDS.
    - The load edge is followed by exactly ROUNDS EXPAND edges. rk_valid is first high in the cycle after the ROUNDSth EXPAND edge, with o_round_idx=ROUNDS.
  - EMIT:
    - rk_valid=1; o_round_idx=ctr.
    - rk_valid & rk_ready & ctr>0: key_reg<=dec_step(key_reg, ctr), ctr<=ctr-1.
    - rk_valid & rk_ready & ctr==0: state<=DONE.
    - rk_ready=0: all outputs held stable (no bubble, no change).
  - DONE: done=1 for one cycle, busy=0, rk_valid=0; next edge goes to IDLE.
- Output timing:
  - One key per cycle when rk_ready is held high. Back-to-back keys have no idle cycles.
  - busy=1 in EXPAND and EMIT; rk_valid=1 only in EMIT.
  - Outputs are registered or decoded from registered state only; there is no combinational path from rk_ready to rk_valid.
- Boundary cases:
  - key_load in the same cycle as the final handshake: ignored.
  - key_load in DONE: ignored; it is accepted from IDLE on a later cycle.
  - Reset mid-EXPAND or mid-EMIT: immediate return to reset values; a new load is needed.
  - ctr arithmetic is 5-bit. It never wraps because ctr stays within 0..ROUNDS.
- Total per key: 1 load edge + ROUNDS expand edges + (ROUNDS+1) handshakes + 1 DONE cycle.

Decomposition:
- Package boron_pkg holds:
  - KEY_W, RK_W, ROUNDS, ROT;
  - the 4-bit S-box table E,4,B,1,7,9,C,A,D,2,0,F,8,5,3,6 and its inverse;
  - state enum {IDLE, EXPAND, EMIT, DONE}.
- One new sub-module, enc_key_step (combinational forward step F). The backward step instantiates dec_key_scheduler.

Test Plan:
1. Load K0=0, rk_ready=1 constantly:
   - rk_valid rises exactly ROUNDS edges after load;
   - 26 keys are emitted with idx 25..0;
   - the idx-0 key equals 0;
   - done pulses once.
2. Load K0=80'hFFFF_FFFF_FFFF_FFFF_FFFF:
   - the idx-25 key equals 25 software-model forward steps (key[63:0]);
   - each next key equals the model's inverse;
   - the last key equals K0[63:0].
3. Stall: rk_ready low for 5 cycles at idx 12:
   - o_round_key/o_round_idx are stable and rk_valid stays 1;
   - release yields idx 11 next.
4. Reset pulse (rst=0) during EXPAND at ctr=10:
   - all outputs go to 0 immediately;
   - a following load of 80'h0123_4567_89AB_CDEF_0123 completes normally.
5. key_load held high throughout a run with a different i_key:
   - ignored while busy;
   - a second run starts only from IDLE after done;
   - the emitted sequence for run 1 is unchanged.
6. Random rk_ready (50%) with 20 random keys:
   - exactly 26 handshakes per key;
   - the final key equals i_key[63:0];
   - no rk_valid outside EMIT.

Source files
------------

// File: rtl/boron_pkg.sv
// Shared constants, S-box tables and FSM state encoding for the BORON key-supply path.
package boron_pkg;

  localparam int KEY_W  = 80;
  localparam int RK_W   = 64;
  localparam int ROUNDS = 25;
  localparam int ROT    = 13;
  localparam int CTR_W  = 5;

  // Nibble i of each table sits at bits [4*i+3:4*i].
  localparam logic [63:0] SBOX     = 64'h6358_F02D_AC97_1B4E;
  localparam logic [63:0] INV_SBOX = 64'hB086_275C_4FD1_E93A;

  typedef enum logic [1:0] {IDLE, EXPAND, EMIT, DONE} state_t;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return SBOX[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] inv_sbox4(input logic [3:0] x);
    return INV_SBOX[{x, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/dec_key_scheduler.sv
// Combinational backward key-schedule step: maps K_r back to K_{r-1} for round_counter = r.
module dec_key_scheduler
  import boron_pkg::*;
(
  input  logic [KEY_W-1:0] key_in,
  input  logic [CTR_W-1:0] round_counter,
  output logic [KEY_W-1:0] key_out
);

  logic [KEY_W-1:0] t;
  logic [CTR_W-1:0] rc;

  always_comb begin
    rc       = round_counter - CTR_W'(1);
    t        = key_in;
    t[63:59] = key_in[63:59] ^ rc;
    t[3:0]   = inv_sbox4(key_in[3:0]);
    key_out  = {t[ROT-1:0], t[KEY_W-1:ROT]};
  end

endmodule

// File: rtl/enc_key_step.sv
// Combinational forward key-schedule step: K_r = F(K_{r-1}, r).
module enc_key_step
  import boron_pkg::*;
(
  input  logic [KEY_W-1:0] key_in,
  input  logic [CTR_W-1:0] round_idx,
  output logic [KEY_W-1:0] key_out
);

  logic [KEY_W-1:0] rot;
  logic [CTR_W-1:0] rc;

  always_comb begin
    rot            = {key_in[KEY_W-1-ROT:0], key_in[KEY_W-1:KEY_W-ROT]};
    rc             = round_idx - CTR_W'(1);
    key_out        = rot;
    key_out[3:0]   = sbox4(rot[3:0]);
    key_out[63:59] = rot[63:59] ^ rc;
  end

endmodule

// File: rtl/dec_round_key_sequencer.sv
// Expands the master key forward to K_ROUNDS, then streams round keys K_ROUNDS..K0 to the
// decryption rounds. Handshake: a key transfers on a rising edge where rk_valid & rk_ready;
// while rk_valid=1 and rk_ready=0 the key and index stay frozen, and rk_valid never depends on rk_ready.
module dec_round_key_sequencer
  import boron_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             key_load,
  input  logic [KEY_W-1:0] i_key,
  output logic             busy,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [RK_W-1:0]  o_round_key,
  output logic [CTR_W-1:0] o_round_idx,
  output logic             done,
  output state_t           dbg_state
);

  state_t           state;
  logic [KEY_W-1:0] key_reg;
  logic [CTR_W-1:0] ctr;
  logic [KEY_W-1:0] fwd_key;
  logic [KEY_W-1:0] bwd_key;

  enc_key_step u_enc_step (
    .key_in    (key_reg),
    .round_idx (ctr),
    .key_out   (fwd_key)
  );

  dec_key_scheduler u_dec_step (
    .key_in        (key_reg),
    .round_counter (ctr),
    .key_out       (bwd_key)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      key_reg <= '0;
      ctr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (key_load) begin
            key_reg <= i_key;
            ctr     <= CTR_W'(1);
            state   <= EXPAND;
          end
        end
        EXPAND: begin
          key_reg <= fwd_key;
          // ctr stays at ROUNDS so the first emitted index is ROUNDS.
          if (ctr == CTR_W'(ROUNDS)) state <= EMIT;
          else                       ctr   <= ctr + CTR_W'(1);
        end
        EMIT: begin
          if (rk_ready) begin
            if (ctr != '0) begin
              key_reg <= bwd_key;
              ctr     <= ctr - CTR_W'(1);
            end else begin
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy        = (state == EXPAND) || (state == EMIT);
  assign rk_valid    = (state == EMIT);
  assign done        = (state == DONE);
  assign o_round_key = key_reg[RK_W-1:0];
  assign o_round_idx = ctr;
  assign dbg_state   = state;

endmodule
